sensor_frame_ctrl: RTL and testbench
====================================

# sensor_frame_ctrl

Parametrised line-sensor drive and readout-accounting block: generates SENSOR_CLK and the ST start pulse, synchronises the EOC/EOS returns from the sensor, and counts pixels per frame. It supports continuous and one-shot acquisition, and checks each frame's pixel count against an expected length. It sits between the sensor pins and downstream capture/LED logic, and runs entirely on FPGA_CLK with clock-enable ticks.

## Interface
- DIV, 8: FPGA_CLK cycles per SENSOR_CLK half-period, ≥1.
- ST_PERIOD, 40000: SENSOR_CLK cycles per ST period.
- ST_HIGH, 6000: SENSOR_CLK cycles ST is high per period; 1 ≤ ST_HIGH < ST_PERIOD.
- PIXELS, 1024: expected EOC edges per frame.
- CNT_W, 11: pixel counter width.
- FRM_W, 16: frame number width.
- TIMEOUT, 65535: SENSOR_CLK cycles without EOS before abort; used only with SENSOR_TIMEOUT_EN.
- FPGA_CLK  in  1  system clock.
- FPGA_RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  acquisition enable.
- ONESHOT  in  1  1 = one ST period per START; 0 = continuous while ENABLE.
- START  in  1  one-cycle start request (ONESHOT mode); also clears sticky errors.
- EOC  in  1  sensor end-of-conversion, asynchronous.
- EOS  in  1  sensor end-of-scan, asynchronous.
- SENSOR_CLK  out  1  divided sensor clock.
- ST  out  1  sensor start pulse.
- EOC_COUNT  out  CNT_W  live pixel count of current frame.
- FRAME_COUNT  out  CNT_W  pixel count of last closed frame.
- FRAME_VALID  out  1  one-cycle pulse when FRAME_COUNT updates.
- FRAME_NUM  out  FRM_W  closed-frame counter.
- ERR_SHORT / ERR_LONG  out  1 each  sticky: last-checked frame had fewer/more than PIXELS.
- ERR_TIMEOUT  out  1  sticky EOS timeout.
- BUSY  out  1  high when state ≠ IDLE.

## Operation
- Reset: all outputs 0; state IDLE; all counters 0.
- Divider: free-running counter 0..DIV-1; at DIV-1 it wraps and SENSOR_CLK toggles. rise_tick/fall_tick mark the cycle where SENSOR_CLK goes 0→1 / 1→0.
- EOC/EOS: 2-FF synchroniser, a third delay FF, and a rising-edge pulse (s2 & ~s3) one FPGA_CLK wide.
- FSM IDLE → RUN: evaluated on fall_tick when ENABLE & (ONESHOT ? start_pending : 1). start_pending is set by START and cleared on entering RUN. Entering RUN sets st_cnt = 0.
- RUN: st_cnt advances on each fall_tick, 0..ST_PERIOD-1.
  - ST is registered high while st_cnt ≥ ST_PERIOD−ST_HIGH.
  - At wrap, go to DRAIN if ONESHOT or !ENABLE; otherwise continue.
- DRAIN: ST low, st_cnt held. Go to IDLE on the next EOS edge.
- EOC edge while state ≠ IDLE: EOC_COUNT +1, saturating at 2^CNT_W−1. EOC and EOS edges in IDLE are ignored.
- EOS edge while state ≠ IDLE:
  - FRAME_COUNT ← final count, EOC_COUNT ← 0, FRAME_VALID = 1, FRAME_NUM +1 (wraps).
  - ERR_SHORT |= count < PIXELS; ERR_LONG |= count > PIXELS.
- Simultaneous EOC and EOS edge: the EOC is included in the closing frame's count.
- START clears ERR_SHORT, ERR_LONG and ERR_TIMEOUT. If START and a set condition occur in the same cycle, set wins.
- ENABLE falling mid-RUN: the current ST period completes, then DRAIN.

## Timing
- First SENSOR_CLK rise occurs on FPGA_CLK edge DIV after reset release. SENSOR_CLK period = 2·DIV FPGA_CLK cycles.
- ST changes only on fall_tick, giving half a SENSOR_CLK period of setup to the next rising edge.
- EOC/EOS latency: EOC_COUNT, FRAME_COUNT and FRAME_VALID update on the 3rd FPGA_CLK edge, counting the edge that first samples the input high.
- EOC/EOS high or low time must be ≥ 2 FPGA_CLK cycles.
- Reset mid-operation: outputs go to reset values immediately (asynchronous); no frame is reported.

## Configuration
- SENSOR_TIMEOUT_EN defined:
  - In RUN/DRAIN, a fall_tick counter restarts on each EOS edge and on entering RUN.
  - When it reaches TIMEOUT: ERR_TIMEOUT ← 1, EOC_COUNT ← 0, state ← IDLE, ST ← 0, no FRAME_VALID.
- Undefined: no timeout logic; ERR_TIMEOUT tied 0 (port always present).

## Test plan
All scenarios use DIV=2, ST_PERIOD=20, ST_HIGH=4, PIXELS=8, CNT_W=11, TIMEOUT=64.
- Reset release, ENABLE=0 → SENSOR_CLK period 4 cycles, first rise on edge 2; ST=0, BUSY=0, all counts 0.
- Continuous mode, ENABLE=1, 8 EOC pulses then EOS, repeated 3 times → ST high 4 of every 20 SENSOR_CLKs; FRAME_VALID ×3, FRAME_COUNT=8, FRAME_NUM=3, no errors.
- ONESHOT=1, START pulse, 5 EOCs + EOS → exactly one ST pulse, FRAME_COUNT=5, ERR_SHORT=1, BUSY=0 after EOS; next START clears ERR_SHORT.
- 9 EOCs, with the 9th EOC and EOS rising in the same cycle → FRAME_COUNT=9, ERR_LONG=1, EOC_COUNT=0 afterwards.
- EOC/EOS pulses while IDLE; FPGA_RST asserted mid-frame after 4 EOCs → counts unchanged while idle; after reset all outputs 0, no FRAME_VALID.
- With SENSOR_TIMEOUT_EN, RUN with no EOS for 64 SENSOR_CLKs → ERR_TIMEOUT=1, BUSY=0, ST=0; without the macro, ERR_TIMEOUT stays 0 and BUSY stays 1.

Source files
------------

// File: rtl/sensor_frame_ctrl.sv
// Line-sensor drive (SENSOR_CLK, ST) and EOC/EOS readout accounting with per-frame length checks.
// Define SENSOR_TIMEOUT_EN to build the EOS watchdog; otherwise err_timeout_o is tied low.
module sensor_frame_ctrl #(
  parameter int unsigned DIV       = 8,
  parameter int unsigned ST_PERIOD = 40000,
  parameter int unsigned ST_HIGH   = 6000,
  parameter int unsigned PIXELS    = 1024,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned FRM_W     = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic             fpga_clk_i,
  input  logic             fpga_rst_i,
  input  logic             enable_i,
  input  logic             oneshot_i,
  input  logic             start_i,
  input  logic             eoc_i,
  input  logic             eos_i,
  output logic             sensor_clk_o,
  output logic             st_o,
  output logic [CNT_W-1:0] eoc_count_o,
  output logic [CNT_W-1:0] frame_count_o,
  output logic             frame_valid_o,
  output logic [FRM_W-1:0] frame_num_o,
  output logic             err_short_o,
  output logic             err_long_o,
  output logic             err_timeout_o,
  output logic             busy_o
);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned StW  = (ST_PERIOD > 1) ? $clog2(ST_PERIOD) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(DIV - 1);
  localparam logic [StW-1:0]   StLast  = StW'(ST_PERIOD - 1);
  localparam logic [StW-1:0]   StOn    = StW'(ST_PERIOD - ST_HIGH);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  logic [DivW-1:0]  div_q;
  logic             sclk_q;
  logic             fall_tick;
  logic [2:0]       eoc_sync_q, eos_sync_q;
  logic             eoc_edge, eos_edge;
  state_e           state_q;
  logic [StW-1:0]   st_cnt_q, st_cnt_d;
  logic             st_q, start_pend_q, frame_valid_q, err_short_q, err_long_q;
  logic [CNT_W-1:0] eoc_count_q, frame_count_q, eoc_inc_d, eoc_final_d;
  logic [FRM_W-1:0] frame_num_q;
  logic             active, abort;

  // SENSOR_CLK falls in the cycle after fall_tick; ST is updated on that same edge.
  assign fall_tick = (div_q == DivLast) & sclk_q;

  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (div_q == DivLast) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) begin
      eoc_sync_q <= '0;
      eos_sync_q <= '0;
    end else begin
      eoc_sync_q <= {eoc_sync_q[1:0], eoc_i};
      eos_sync_q <= {eos_sync_q[1:0], eos_i};
    end
  end

  assign eoc_edge = eoc_sync_q[1] & ~eoc_sync_q[2];
  assign eos_edge = eos_sync_q[1] & ~eos_sync_q[2];
  assign active   = (state_q != StIdle);

  always_comb begin
    eoc_inc_d   = (eoc_count_q == CntMax) ? eoc_count_q : eoc_count_q + 1'b1;
    eoc_final_d = eoc_edge ? eoc_inc_d : eoc_count_q;
    st_cnt_d    = st_cnt_q + 1'b1;
  end

  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) begin
      state_q       <= StIdle;
      st_cnt_q      <= '0;
      st_q          <= 1'b0;
      start_pend_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      eoc_count_q   <= '0;
      frame_count_q <= '0;
      frame_num_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      if (start_i) begin
        start_pend_q <= 1'b1;
        err_short_q  <= 1'b0;
        err_long_q   <= 1'b0;
      end
      if (active && eoc_edge) eoc_count_q <= eoc_inc_d;
      // A coincident EOC edge is folded into the closing frame via eoc_final_d.
      if (active && eos_edge) begin
        frame_count_q <= eoc_final_d;
        eoc_count_q   <= '0;
        frame_valid_q <= 1'b1;
        frame_num_q   <= frame_num_q + 1'b1;
        if (32'(eoc_final_d) < PIXELS) err_short_q <= 1'b1;
        if (32'(eoc_final_d) > PIXELS) err_long_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (fall_tick && enable_i && (!oneshot_i || start_pend_q)) begin
            state_q      <= StRun;
            st_cnt_q     <= '0;
            st_q         <= 1'b0;
            start_pend_q <= 1'b0;
          end
        end
        StRun: begin
          if (fall_tick) begin
            if (st_cnt_q == StLast) begin
              st_cnt_q <= '0;
              st_q     <= 1'b0;
              if (oneshot_i || !enable_i) state_q <= StDrain;
            end else begin
              st_cnt_q <= st_cnt_d;
              st_q     <= (st_cnt_d >= StOn);
            end
          end
        end
        StDrain: begin
          if (eos_edge) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (abort) begin
        state_q     <= StIdle;
        st_q        <= 1'b0;
        eoc_count_q <= '0;
      end
    end
  end

`ifdef SENSOR_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] to_cnt_q;
  logic           err_to_q;

  // An EOS edge in the same cycle always rescues the frame.
  assign abort = active && !eos_edge && fall_tick && (to_cnt_q == ToW'(TIMEOUT - 1));

  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (start_i) err_to_q <= 1'b0;
      if (!active || eos_edge || abort) to_cnt_q <= '0;
      else if (fall_tick)               to_cnt_q <= to_cnt_q + 1'b1;
      if (abort) err_to_q <= 1'b1;
    end
  end

  assign err_timeout_o = err_to_q;
`else
  assign abort         = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  assign sensor_clk_o  = sclk_q;
  assign st_o          = st_q;
  assign eoc_count_o   = eoc_count_q;
  assign frame_count_o = frame_count_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_num_o   = frame_num_q;
  assign err_short_o   = err_short_q;
  assign err_long_o    = err_long_q;
  assign busy_o        = active;
endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// Bench for sensor_frame_ctrl: directed scenarios with randomised EOC/EOS pulse timing,
// checked against a frame-level model of pixel counts, frame numbers and sticky errors.
`timescale 1ns/1ps
module tb_sensor_frame_ctrl;
  localparam int unsigned DIV = 2, ST_PERIOD = 20, ST_HIGH = 4, PIXELS = 8;
  localparam int unsigned CNT_W = 11, FRM_W = 16, TIMEOUT = 64;
  localparam int unsigned SCLK_CYC = 2 * DIV;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic enable = 1'b0, oneshot = 1'b0, start = 1'b0, eoc = 1'b0, eos = 1'b0;
  logic sclk, st, fv, e_short, e_long, e_to, busy;
  logic [CNT_W-1:0] eoc_cnt, frm_cnt;
  logic [FRM_W-1:0] frm_num;

  int n_cmp = 0, n_fail = 0, fv_cnt = 0;
  int exp_cnt = 0, exp_fc = 0, exp_num = 0, exp_fv = 0;
  bit exp_short = 0, exp_long = 0, exp_to = 0, exp_active = 0;

  sensor_frame_ctrl #(
    .DIV(DIV), .ST_PERIOD(ST_PERIOD), .ST_HIGH(ST_HIGH), .PIXELS(PIXELS),
    .CNT_W(CNT_W), .FRM_W(FRM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .fpga_clk_i(clk), .fpga_rst_i(rst), .enable_i(enable), .oneshot_i(oneshot),
    .start_i(start), .eoc_i(eoc), .eos_i(eos), .sensor_clk_o(sclk), .st_o(st),
    .eoc_count_o(eoc_cnt), .frame_count_o(frm_cnt), .frame_valid_o(fv),
    .frame_num_o(frm_num), .err_short_o(e_short), .err_long_o(e_long),
    .err_timeout_o(e_to), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fv === 1'b1) fv_cnt++;
  endtask

  // One EOC and/or EOS pulse with random high/low widths (each >= 2 cycles).
  task automatic pulse(input bit c, input bit s);
    int hi, lo;
    hi = $urandom_range(2, 4);
    lo = $urandom_range(2, 4);
    eoc = c;
    eos = s;
    repeat (hi) step();
    eoc = 1'b0;
    eos = 1'b0;
    repeat (lo) step();
    if (exp_active) begin
      if (c && exp_cnt < CNT_SAT) exp_cnt++;
      if (s) begin
        exp_fc    = exp_cnt;
        exp_cnt   = 0;
        exp_num   = (exp_num + 1) % (1 << FRM_W);
        exp_fv++;
        exp_short = exp_short | (exp_fc < PIXELS);
        exp_long  = exp_long | (exp_fc > PIXELS);
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_short = 0;
    exp_long  = 0;
    exp_to    = 0;
  endtask

  task automatic wait_st(input logic level, input int bound, output int n, output bit ok);
    n  = 0;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      n++;
      if (st === level) ok = 1;
    end
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_frame_count"}, 32'(frm_cnt), exp_fc);
    chk({tag, "_frame_num"}, 32'(frm_num), exp_num);
    chk({tag, "_eoc_count"}, 32'(eoc_cnt), exp_cnt);
    chk({tag, "_err_short"}, 32'(e_short), 32'(exp_short));
    chk({tag, "_err_long"}, 32'(e_long), 32'(exp_long));
    chk({tag, "_valid_pulses"}, fv_cnt, exp_fv);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bits"}, {25'd0, sclk, st, fv, e_short, e_long, e_to, busy}, 0);
    chk({tag, "_counts"}, {10'd0, eoc_cnt, frm_cnt}, 0);
    chk({tag, "_frame_num"}, 32'(frm_num), 0);
  endtask

  initial begin
    int n, rises;
    bit ok;
    logic prev;

    // Reset state and free-running divider.
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("sclk_edge%0d", k), 32'(sclk), (k / DIV) % 2);
    end
    chk("idle_st_busy", {30'd0, st, busy}, 0);
    chk("idle_counts", {10'd0, eoc_cnt, frm_cnt}, 0);

    // Continuous mode: ST timing, then three nominal frames.
    enable = 1'b1;
    wait_st(1'b1, 200, n, ok);
    chk("cont_st_rise_seen", 32'(ok), 1);
    wait_st(1'b0, 100, n, ok);
    chk("cont_st_high_cycles", n, ST_HIGH * SCLK_CYC);
    wait_st(1'b1, 200, n, ok);
    chk("cont_st_low_cycles", n, (ST_PERIOD - ST_HIGH) * SCLK_CYC);
    chk("cont_busy", 32'(busy), 1);
    exp_active = 1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 8; p++) pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    chk_frame("cont3");

    // ENABLE drop: period completes, DRAIN waits for EOS, empty frame is short.
    enable = 1'b0;
    repeat (ST_PERIOD * SCLK_CYC * 2 + 20) step();
    chk("drain_st", 32'(st), 0);
    chk("drain_busy", 32'(busy), 1);
    pulse(1'b0, 1'b1);
    exp_active = 0;
    chk_frame("drain_eos");
    chk("drain_idle", 32'(busy), 0);

    // One-shot: a single ST pulse, short frame, START clears the sticky error.
    oneshot = 1'b1;
    enable  = 1'b1;
    do_start();
    chk("os_start_clears_short", 32'(e_short), 0);
    prev  = st;
    rises = 0;
    repeat (150) begin
      step();
      if (st && !prev) rises++;
      prev = st;
    end
    chk("os_st_pulses", rises, 1);
    chk("os_drain_busy", 32'(busy), 1);
    exp_active = 1;
    for (int p = 0; p < 5; p++) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    exp_active = 0;
    chk_frame("os_short");
    repeat (100) step();
    chk("os_no_retrigger", 32'(busy), 0);

    // Long frame with the ninth EOC coincident with EOS; checks EOC latency too.
    do_start();
    chk("long_start_clears_short", 32'(e_short), 0);
    repeat (120) step();
    exp_active = 1;
    eoc = 1'b1;
    step();
    step();
    chk("eoc_latency_edge2", 32'(eoc_cnt), 0);
    step();
    chk("eoc_latency_edge3", 32'(eoc_cnt), 1);
    eoc = 1'b0;
    repeat (3) step();
    exp_cnt = 1;
    for (int p = 0; p < 7; p++) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    exp_active = 0;
    chk_frame("long_coincident");
    chk("long_idle", 32'(busy), 0);

    // EOC/EOS ignored in IDLE; then reset mid-frame.
    for (int p = 0; p < 3; p++) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk_frame("idle_ignored");
    do_start();
    repeat (10) step();
    chk("midrst_busy", 32'(busy), 1);
    exp_active = 1;
    for (int p = 0; p < 4; p++) pulse(1'b1, 1'b0);
    chk("midrst_eoc_count", 32'(eoc_cnt), exp_cnt);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    exp_cnt = 0; exp_fc = 0; exp_num = 0;
    exp_short = 0; exp_long = 0; exp_active = 0;
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    chk_frame("post_reset");
    chk("post_reset_busy", 32'(busy), 0);

    // EOS watchdog: one-shot run that never sees EOS.
    do_start();
    repeat (10) step();
    exp_active = 1;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (280) step();
`ifdef SENSOR_TIMEOUT_EN
    exp_cnt = 0;
    exp_to  = 1;
    chk("to_busy", 32'(busy), 0);
`else
    chk("to_busy", 32'(busy), 1);
`endif
    chk("to_flag", 32'(e_to), 32'(exp_to));
    chk("to_st", 32'(st), 0);
    chk("to_eoc_count", 32'(eoc_cnt), exp_cnt);
    chk("to_valid_pulses", fv_cnt, exp_fv);
    do_start();
    chk("to_start_clears", 32'(e_to), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
